dds_par_receiver: RTL
=====================

# dds_par_receiver

Responder end of the DDS parallel programming port. Samples the 6-bit address, 8-bit data and WRITE strobe driven by the DDS programming sequencer into a buffer register bank. Transfers the buffer to the active register bank on the update strobe (the sequencer's READY). Serves as the on-chip register front end for the internal DDS core and as the bench model of the external DDS chip.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth for WRITE, UPDATE and DRESET (minimum 2).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- AIN  in  6  register address from the sequencer (AOUT).
- DIN  in  8  register data from the sequencer (DOUT).
- WRITE  in  1  asynchronous write strobe; a write occurs on its rising edge.
- UPDATE  in  1  asynchronous update strobe (READY); the update occurs on its rising edge.
- DRESET  in  1  asynchronous DDS reset level (sequencer RESET).
- FTW1  out  48  active frequency tuning word 1.
- FTW2  out  48  active frequency tuning word 2.
- DFW  out  48  active delta-frequency word.
- PTW1, PTW2  out  14 each  active phase words.
- RAMPRATE  out  20  active ramp-rate clock count.
- MODE  out  3  active mode; TRIANGLE  out  1.
- CLKMULT  out  5; PLLEN  out  1; PLLRANGE  out  1.
- CTRL20  out  8  raw control byte at address 0x20.
- UPD_DONE  out  1  one-cycle pulse when the active bank is loaded.
- WR_CNT  out  8  count of accepted writes, wraps 0xFF→0x00.
- ADDRERR  out  1  sticky undefined-address flag.

## Operation
- WRITE, UPDATE and DRESET each pass through a SYNC_STAGES flop chain plus an edge detector. AIN and DIN are sampled in the cycle the WRITE rising edge is detected; the sequencer holds them stable for hundreds of CLK cycles.
- Address map, buffer bank:
  - 0x00: PTW1[13:8] = DIN[5:0]. 0x01: PTW1[7:0].
  - 0x02: PTW2[13:8] = DIN[5:0]. 0x03: PTW2[7:0].
  - 0x04–0x09: FTW1 bytes [47:40] down to [7:0]. 0x0A–0x0F: FTW2, same order. 0x10–0x15: DFW, same order.
  - 0x1A: RAMPRATE[19:16] = DIN[3:0]. 0x1B: RAMPRATE[15:8]. 0x1C: RAMPRATE[7:0].
  - 0x1E: PLLRANGE = DIN[6], PLLEN = DIN[5], CLKMULT = DIN[4:0].
  - 0x1F: MODE = DIN[6:4], TRIANGLE = DIN[2].
  - 0x20: CTRL20 = DIN.
  - All other addresses are undefined. Writes to them are not stored and do not increment WR_CNT.
- Accepted writes increment WR_CNT.
- UPDATE rising edge: the whole buffer bank is copied to the active bank and UPD_DONE is pulsed in the same cycle as the copy.
- DRESET (synchronised) high: buffer and active banks are held at zero, WR_CNT is held at 0, and write and update edges are ignored. When DRESET falls, normal operation resumes the next cycle.
- State machine: IDLE → WRITE (1 cycle, buffer store) → IDLE; IDLE → LOAD (1 cycle, copy, UPD_DONE) → IDLE; any state → CLEAR while DRESET is high; CLEAR → IDLE when DRESET is low.
- Write and update edges detected in the same cycle: the write is stored and the copy includes the new byte (write-through to active).

## Timing
- Reset: all outputs are 0, including WR_CNT, ADDRERR and UPD_DONE; the state machine is in IDLE.
- Latency from WRITE rising at the pin to the buffer register being updated: SYNC_STAGES+1 CLK.
- Latency from UPDATE rising at the pin to active outputs and UPD_DONE: SYNC_STAGES+1 CLK.
- Minimum strobe high and low width: SYNC_STAGES+1 CLK. Narrower pulses may be missed; they never cause a double write.
- Active outputs change only in the LOAD or CLEAR cycle. They are glitch-free between these cycles.
- Asserting RST mid-operation overrides everything immediately and clears all state.

## Configuration
- DDS_RX_ADDRCHK_EN defined:
  - ADDRERR is set on a write to an undefined address.
  - ADDRERR is cleared only by RST or DRESET.
- Undefined: ADDRERR is tied to 0 and writes to undefined addresses are silently dropped.

## Structure
- Shared package dds_pkg:
  - address constants (ADDR_PTW1H through ADDR_CTRL20);
  - MODE encodings (single-tone 3'b000, FSK 3'b001, ramped FSK 3'b010, chirp 3'b011, BPSK 3'b100);
  - bank reset defaults.
- Sub-module dds_rx_sync: SYNC_STAGES flop chain plus rising-edge pulse output. It is instantiated three times (WRITE, UPDATE, DRESET).

## Test plan
- RST, then write FTW1 bytes 0x04..0x09 = 0x12,0x34,0x56,0x78,0x9A,0xBC, without UPDATE → FTW1 stays 0 and WR_CNT = 6. After UPDATE → FTW1 = 0x123456789ABC and UPD_DONE is high for exactly 1 cycle.
- Write 0x1F = 0x34, 0x1E = 0x6A, then UPDATE → MODE = 3'b011, TRIANGLE = 1, PLLRANGE = 1, PLLEN = 1, CLKMULT = 0x0A.
- Write 0x00 = 0xFF, 0x01 = 0xAB, 0x1A = 0xF7, then UPDATE → PTW1 = 0x3FAB and RAMPRATE[19:16] = 0x7.
- Write 0x16 = 0x55 → WR_CNT is unchanged. With DDS_RX_ADDRCHK_EN, ADDRERR = 1 until DRESET; without it, ADDRERR = 0.
- Load values, then assert DRESET for 10 CLK → all active outputs = 0; a WRITE pulse during DRESET is ignored.
- Write and UPDATE edges arriving in the same cycle (0x09 = 0x77) → FTW1[7:0] = 0x77 after the copy. Separately, 300 writes → WR_CNT = 0x2C (wrap).

Source files
------------

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS parallel programming port: register map,
// mode encodings, register bank layout and the buffer-bank write decoder.
package dds_pkg;

  localparam logic [5:0] ADDR_PTW1H   = 6'h00;
  localparam logic [5:0] ADDR_PTW1L   = 6'h01;
  localparam logic [5:0] ADDR_PTW2H   = 6'h02;
  localparam logic [5:0] ADDR_PTW2L   = 6'h03;
  localparam logic [5:0] ADDR_FTW1_0  = 6'h04;
  localparam logic [5:0] ADDR_FTW1_5  = 6'h09;
  localparam logic [5:0] ADDR_FTW2_0  = 6'h0A;
  localparam logic [5:0] ADDR_FTW2_5  = 6'h0F;
  localparam logic [5:0] ADDR_DFW_0   = 6'h10;
  localparam logic [5:0] ADDR_DFW_5   = 6'h15;
  localparam logic [5:0] ADDR_RAMP2   = 6'h1A;
  localparam logic [5:0] ADDR_RAMP1   = 6'h1B;
  localparam logic [5:0] ADDR_RAMP0   = 6'h1C;
  localparam logic [5:0] ADDR_PLL     = 6'h1E;
  localparam logic [5:0] ADDR_MODE    = 6'h1F;
  localparam logic [5:0] ADDR_CTRL20  = 6'h20;

  typedef enum logic [2:0] {
    MODE_SINGLE   = 3'b000,
    MODE_FSK      = 3'b001,
    MODE_RAMP_FSK = 3'b010,
    MODE_CHIRP    = 3'b011,
    MODE_BPSK     = 3'b100
  } dds_mode_t;

  typedef struct packed {
    logic [13:0] ptw1;
    logic [13:0] ptw2;
    logic [47:0] ftw1;
    logic [47:0] ftw2;
    logic [47:0] dfw;
    logic [19:0] ramprate;
    dds_mode_t   mode;
    logic        triangle;
    logic [4:0]  clkmult;
    logic        pllen;
    logic        pllrange;
    logic [7:0]  ctrl20;
  } dds_bank_t;

  localparam dds_bank_t BANK_RESET = '0;

  function automatic logic addr_valid(input logic [5:0] a);
    logic ok;
    ok = 1'b0;
    case (a) inside
      ADDR_PTW1H, ADDR_PTW1L, ADDR_PTW2H, ADDR_PTW2L,
      [ADDR_FTW1_0:ADDR_FTW1_5], [ADDR_FTW2_0:ADDR_FTW2_5], [ADDR_DFW_0:ADDR_DFW_5],
      ADDR_RAMP2, ADDR_RAMP1, ADDR_RAMP0, ADDR_PLL, ADDR_MODE, ADDR_CTRL20: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte index 0 is the most significant byte of the 48-bit word.
  function automatic logic [47:0] put_byte48(input logic [47:0] w, input logic [2:0] k,
                                             input logic [7:0] d);
    logic [47:0] r;
    r = w;
    case (k)
      3'd0: r[47:40] = d;
      3'd1: r[39:32] = d;
      3'd2: r[31:24] = d;
      3'd3: r[23:16] = d;
      3'd4: r[15:8]  = d;
      3'd5: r[7:0]   = d;
      default: ;
    endcase
    return r;
  endfunction

  function automatic dds_bank_t bank_write(input dds_bank_t b, input logic [5:0] a,
                                           input logic [7:0] d);
    dds_bank_t r;
    r = b;
    case (a) inside
      ADDR_PTW1H:  r.ptw1[13:8] = d[5:0];
      ADDR_PTW1L:  r.ptw1[7:0]  = d;
      ADDR_PTW2H:  r.ptw2[13:8] = d[5:0];
      ADDR_PTW2L:  r.ptw2[7:0]  = d;
      [ADDR_FTW1_0:ADDR_FTW1_5]: r.ftw1 = put_byte48(r.ftw1, 3'(a - ADDR_FTW1_0), d);
      [ADDR_FTW2_0:ADDR_FTW2_5]: r.ftw2 = put_byte48(r.ftw2, 3'(a - ADDR_FTW2_0), d);
      [ADDR_DFW_0:ADDR_DFW_5]:   r.dfw  = put_byte48(r.dfw,  3'(a - ADDR_DFW_0),  d);
      ADDR_RAMP2:  r.ramprate[19:16] = d[3:0];
      ADDR_RAMP1:  r.ramprate[15:8]  = d;
      ADDR_RAMP0:  r.ramprate[7:0]   = d;
      ADDR_PLL: begin
        r.pllrange = d[6];
        r.pllen    = d[5];
        r.clkmult  = d[4:0];
      end
      ADDR_MODE: begin
        r.mode     = dds_mode_t'(d[6:4]);
        r.triangle = d[2];
      end
      ADDR_CTRL20: r.ctrl20 = d;
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dds_rx_sync.sv
// Strobe synchroniser: STAGES-deep flop chain, output either the synchronised
// level or a one-cycle rising-edge pulse (EDGE_OUT).
module dds_rx_sync #(
  parameter int STAGES   = 2,
  parameter bit EDGE_OUT = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic async_in,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) chain <= '0;
    else     chain <= {chain[STAGES-2:0], async_in};
  end

  generate
    if (EDGE_OUT) begin : g_edge
      logic prev;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) prev <= 1'b0;
        else     prev <= chain[STAGES-1];
      end
      assign q = chain[STAGES-1] & ~prev;
    end else begin : g_level
      assign q = chain[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/dds_par_receiver.sv
// DDS parallel-port responder: buffer bank written by WRITE, copied to the
// active bank on UPDATE. Optional ADDRERR checking under DDS_RX_ADDRCHK_EN.
module dds_par_receiver
  import dds_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [5:0]  AIN,
  input  logic [7:0]  DIN,
  input  logic        WRITE,
  input  logic        UPDATE,
  input  logic        DRESET,
  output logic [47:0] FTW1,
  output logic [47:0] FTW2,
  output logic [47:0] DFW,
  output logic [13:0] PTW1,
  output logic [13:0] PTW2,
  output logic [19:0] RAMPRATE,
  output logic [2:0]  MODE,
  output logic        TRIANGLE,
  output logic [4:0]  CLKMULT,
  output logic        PLLEN,
  output logic        PLLRANGE,
  output logic [7:0]  CTRL20,
  output logic        UPD_DONE,
  output logic [7:0]  WR_CNT,
  output logic        ADDRERR
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_LOAD, S_CLEAR} rx_state_t;

  rx_state_t state;
  dds_bank_t buf_q, buf_next, act_q;
  logic      wr_rise, upd_rise, dres_level;
  logic      accept, wr_ok, wr_take;

  dds_rx_sync #(.STAGES(SYNC_STAGES), .EDGE_OUT(1'b1)) u_wr_sync (
    .CLK(CLK), .RST(RST), .async_in(WRITE), .q(wr_rise));
  dds_rx_sync #(.STAGES(SYNC_STAGES), .EDGE_OUT(1'b1)) u_upd_sync (
    .CLK(CLK), .RST(RST), .async_in(UPDATE), .q(upd_rise));
  dds_rx_sync #(.STAGES(SYNC_STAGES), .EDGE_OUT(1'b0)) u_dres_sync (
    .CLK(CLK), .RST(RST), .async_in(DRESET), .q(dres_level));

  // Edges seen while still leaving CLEAR are dropped; normal work resumes a cycle later.
  assign accept  = (state != S_CLEAR);
  assign wr_ok   = addr_valid(AIN);
  assign wr_take = accept & wr_rise & wr_ok;

  // NOTE: buf_next gets a full default first so this block can never infer a latch.
  always_comb begin
    buf_next = buf_q;
    if (wr_take) buf_next = bank_write(buf_q, AIN, DIN);
  end

  // NOTE: both banks are plain registers and are reset; nothing reads them before load.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      buf_q    <= BANK_RESET;
      act_q    <= BANK_RESET;
      UPD_DONE <= 1'b0;
      WR_CNT   <= 8'h00;
    end else begin
      UPD_DONE <= 1'b0;
      if (dres_level) begin
        state  <= S_CLEAR;
        buf_q  <= BANK_RESET;
        act_q  <= BANK_RESET;
        WR_CNT <= 8'h00;
      end else begin
        buf_q <= buf_next;
        if (wr_take) WR_CNT <= WR_CNT + 8'd1;
        if (accept && upd_rise) begin
          // Copy from buf_next so a same-cycle write is carried through.
          act_q    <= buf_next;
          UPD_DONE <= 1'b1;
          state    <= S_LOAD;
        end else if (wr_take) begin
          state <= S_WRITE;
        end else begin
          state <= S_IDLE;
        end
      end
    end
  end

`ifdef DDS_RX_ADDRCHK_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                ADDRERR <= 1'b0;
    else if (dres_level)                    ADDRERR <= 1'b0;
    else if (accept && wr_rise && !wr_ok)   ADDRERR <= 1'b1;
  end
`else
  assign ADDRERR = 1'b0;
`endif

  assign FTW1     = act_q.ftw1;
  assign FTW2     = act_q.ftw2;
  assign DFW      = act_q.dfw;
  assign PTW1     = act_q.ptw1;
  assign PTW2     = act_q.ptw2;
  assign RAMPRATE = act_q.ramprate;
  assign MODE     = act_q.mode;
  assign TRIANGLE = act_q.triangle;
  assign CLKMULT  = act_q.clkmult;
  assign PLLEN    = act_q.pllen;
  assign PLLRANGE = act_q.pllrange;
  assign CTRL20   = act_q.ctrl20;

endmodule
